// File: rtl/mem_test_con_pkg.sv
// Shared definitions for the SDRAM/DSEC test sequencer.
//   DEF_ADDR_W            default SDRAM row-address width
//   MEM_WRITE / MEM_READ  encodings of the w_rn strobe
//   state_t               sequencer state encoding
package mem_test_con_pkg;

    localparam int DEF_ADDR_W = 13;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_REQ  = 3'd1,
        ST_W_WAIT = 3'd2,
        ST_R_REQ  = 3'd3,
        ST_R_WAIT = 3'd4,
        ST_D_REQ  = 3'd5,
        ST_D_WAIT = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/mem_test_con_pulse_gen.sv
// Registered one-cycle strobe generator.
//   clk      system clock
//   rst      synchronous active-high reset, clears the strobe
//   i_fire   combinational request, high for the single cycle before the strobe
//   o_pulse  registered strobe, follows i_fire by one clock
module mem_test_con_pulse_gen (
    input  logic clk,
    input  logic rst,
    input  logic i_fire,
    output logic o_pulse
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_pulse <= 1'b0;
        end else begin
            o_pulse <= i_fire;
        end
    end

endmodule

// File: rtl/mem_test_con.sv
// Test sequencer: writes a block of SDRAM words through mem_con, then reads
// the same block back, handing each word to DSEC and waiting for DSEC to
// finish before the next read. Control only; write data comes from elsewhere.
//   clk             system clock
//   rst             synchronous active-high reset
//   address         word address presented to mem_con (registered)
//   w_rn            1 = write, 0 = read (registered)
//   go              one-cycle request strobe to mem_con (registered)
//   memValid        one-cycle completion pulse from mem_con
//   dsec_out_valid  one-cycle pulse, DSEC finished the current word
//   dsec_in_valid   one-cycle pulse, memory word available to DSEC (registered)
//   dsec_rdy        DSEC can accept a word
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | after reset, dwells one cycle then starts the write pass
// ST_W_REQ  | go high, write request to mem_con
// ST_W_WAIT | waiting for memValid of the write
// ST_R_REQ  | go high, read request to mem_con
// ST_R_WAIT | waiting for memValid of the read
// ST_D_REQ  | waiting for dsec_rdy to hand over the word
// ST_D_WAIT | waiting for dsec_out_valid
// ST_DONE   | test block finished, parked until reset
module mem_test_con
    import mem_test_con_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                NUM_WORDS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] address,
    output logic              w_rn,
    output logic              go,
    input  logic              memValid,
    input  logic              dsec_out_valid,
    output logic              dsec_in_valid,
    input  logic              dsec_rdy
);

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_wrn;
    logic              w_wrn_nxt;
    logic              r_armed;
    logic              w_last;
    logic              w_go_fire;
    logic              w_iv_fire;

    assign w_last = (r_cnt == LAST_CNT);

    // r_armed is low only in the first cycle after reset, which is what
    // makes IDLE last one full cycle after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= START_ADDR;
            r_wrn   <= MEM_READ;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wrn   <= w_wrn_nxt;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wrn_nxt   = r_wrn;
        case (r_state)
            ST_IDLE: begin
                if (r_armed) begin
                    w_state_nxt = ST_W_REQ;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = START_ADDR;
                    w_wrn_nxt   = MEM_WRITE;
                end
            end
            ST_W_REQ: w_state_nxt = ST_W_WAIT;
            ST_W_WAIT: begin
                if (memValid) begin
                    if (w_last) begin
                        w_state_nxt = ST_R_REQ;
                        w_cnt_nxt   = '0;
                        w_addr_nxt  = START_ADDR;
                        w_wrn_nxt   = MEM_READ;
                    end else begin
                        w_state_nxt = ST_W_REQ;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_addr_nxt  = r_addr + 1'b1;
                    end
                end
            end
            ST_R_REQ: w_state_nxt = ST_R_WAIT;
            ST_R_WAIT: begin
                if (memValid) begin
                    w_state_nxt = ST_D_REQ;
                end
            end
            ST_D_REQ: begin
                if (dsec_rdy) begin
                    w_state_nxt = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                if (dsec_out_valid) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_R_REQ;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_addr_nxt  = r_addr + 1'b1;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered so they line up with the REQ state itself and
    // with the first D_WAIT cycle; the two can never coincide.
    assign w_go_fire = (w_state_nxt == ST_W_REQ) || (w_state_nxt == ST_R_REQ);
    assign w_iv_fire = (r_state == ST_D_REQ) && dsec_rdy;

    mem_test_con_pulse_gen u_go_pulse (
        .clk     (clk),
        .rst     (rst),
        .i_fire  (w_go_fire),
        .o_pulse (go)
    );

    mem_test_con_pulse_gen u_iv_pulse (
        .clk     (clk),
        .rst     (rst),
        .i_fire  (w_iv_fire),
        .o_pulse (dsec_in_valid)
    );

    assign address = r_addr;
    assign w_rn    = r_wrn;

endmodule

// File: tb/tb_mem_test_con.sv
// Bench for mem_test_con. Two instances share all inputs: one starting at
// address 0, one at 8190 so the second wraps through 0 during its block.
// Each run builds a cycle timeline of the expected transactions from the
// latencies it chooses (write go spacing, read/DSEC hand-off, DSEC busy
// time), drives the inputs from that timeline and compares every cycle.
module tb_mem_test_con;

    localparam int          N    = 4;
    localparam int          MAXC = 256;
    localparam logic [12:0] S_A  = 13'd0;
    localparam logic [12:0] S_B  = 13'd8190;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        dsec_ov = 1'b0;
    logic        dsec_rdy = 1'b1;
    logic [12:0] addr_a, addr_b;
    logic        wrn_a, wrn_b, go_a, go_b, iv_a, iv_b;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    mem_test_con #(.ADDR_W(13), .START_ADDR(S_A), .NUM_WORDS(N)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .address        (addr_a),
        .w_rn           (wrn_a),
        .go             (go_a),
        .memValid       (mem_valid),
        .dsec_out_valid (dsec_ov),
        .dsec_in_valid  (iv_a),
        .dsec_rdy       (dsec_rdy)
    );

    mem_test_con #(.ADDR_W(13), .START_ADDR(S_B), .NUM_WORDS(N)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .address        (addr_b),
        .w_rn           (wrn_b),
        .go             (go_b),
        .memValid       (mem_valid),
        .dsec_out_valid (dsec_ov),
        .dsec_in_valid  (iv_b),
        .dsec_rdy       (dsec_rdy)
    );

    typedef struct {
        int mem_lat;
        int dsec_lat;
        int rdy_hold;
        bit spur;
        bit rnd;
        int exp_go;
        int exp_iv;
        int exp_last_iv;
    } cfg_t;

    // Timeline: inputs to drive and expected strobes per cycle, where cycle 0
    // is the cycle right after the last reset edge.
    logic tl_go[MAXC];
    logic tl_iv[MAXC];
    logic tl_mv[MAXC];
    logic tl_ov[MAXC];
    logic tl_rdy[MAXC];
    int   go_idx[MAXC];
    logic go_wrn[MAXC];
    int   ex_idx[MAXC];
    logic ex_wrn[MAXC];
    int   tl_end;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_go_a"}, -1, 32'(go_a), 0);
        chk({tag, "_iv_a"}, -1, 32'(iv_a), 0);
        chk({tag, "_addr_a"}, -1, 32'(addr_a), 32'(S_A));
        chk({tag, "_wrn_a"}, -1, 32'(wrn_a), 0);
        chk({tag, "_go_b"}, -1, 32'(go_b), 0);
        chk({tag, "_addr_b"}, -1, 32'(addr_b), 32'(S_B));
    endtask

    task automatic build(input cfg_t cfg);
        int t, l, d, r, ivc, cur_idx;
        logic cur_wrn;
        for (int c = 0; c < MAXC; c++) begin
            tl_go[c]  = 1'b0;
            tl_iv[c]  = 1'b0;
            tl_mv[c]  = 1'b0;
            tl_ov[c]  = 1'b0;
            tl_rdy[c] = cfg.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            go_idx[c] = 0;
            go_wrn[c] = 1'b0;
        end
        // IDLE dwells one cycle after release, so the first go is cycle 2.
        t = 2;
        for (int j = 0; j < N; j++) begin
            l = cfg.rnd ? int'($urandom_range(1, 4)) : cfg.mem_lat;
            tl_go[t]  = 1'b1;
            go_idx[t] = j;
            go_wrn[t] = 1'b1;
            tl_mv[t + l] = 1'b1;
            if (cfg.spur) begin
                tl_mv[t]     = 1'b1;
                tl_ov[t]     = 1'b1;
                tl_ov[t + 1] = 1'b1;
            end
            t = t + l + 1;
        end
        for (int j = 0; j < N; j++) begin
            l = cfg.rnd ? int'($urandom_range(1, 4)) : cfg.mem_lat;
            d = cfg.rnd ? int'($urandom_range(1, 6)) : cfg.dsec_lat;
            r = cfg.rnd ? int'($urandom_range(0, 3)) : cfg.rdy_hold;
            tl_go[t]  = 1'b1;
            go_idx[t] = j;
            go_wrn[t] = 1'b0;
            tl_mv[t + l] = 1'b1;
            for (int k = 1; k <= r; k++) tl_rdy[t + l + k] = 1'b0;
            tl_rdy[t + l + r + 1] = 1'b1;
            ivc = t + l + r + 2;
            tl_iv[ivc]     = 1'b1;
            tl_ov[ivc + d] = 1'b1;
            if (cfg.spur) begin
                tl_mv[t]         = 1'b1;
                tl_ov[t + 1]     = 1'b1;
                tl_mv[t + l + 1] = 1'b1;
                tl_mv[ivc]       = 1'b1;
            end
            t = ivc + d + 1;
        end
        if (cfg.spur) begin
            tl_mv[t + 2] = 1'b1;
            tl_ov[t + 4] = 1'b1;
        end
        tl_end = t + 10;
        // Address and direction follow the most recent request.
        cur_idx = 0;
        cur_wrn = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            if (tl_go[c]) begin
                cur_idx = go_idx[c];
                cur_wrn = go_wrn[c];
            end
            ex_idx[c] = cur_idx;
            ex_wrn[c] = cur_wrn;
        end
    endtask

    // Entered #1 after a reset edge with rst already released.
    task automatic run(input cfg_t cfg, input int abort_at, output int n_go, output int n_iv, output int last_iv);
        logic [12:0] ea, eb;
        build(cfg);
        n_go = 0;
        n_iv = 0;
        last_iv = -1;
        for (int c = 0; c < tl_end; c++) begin
            ea = S_A + 13'(ex_idx[c]);
            eb = S_B + 13'(ex_idx[c]);
            chk("go_a", c, 32'(go_a), 32'(tl_go[c]));
            chk("iv_a", c, 32'(iv_a), 32'(tl_iv[c]));
            chk("addr_a", c, 32'(addr_a), 32'(ea));
            chk("wrn_a", c, 32'(wrn_a), 32'(ex_wrn[c]));
            chk("strobes_b", c, {30'd0, go_b, iv_b}, {30'd0, tl_go[c], tl_iv[c]});
            chk("addr_b", c, 32'(addr_b), 32'(eb));
            chk("wrn_b", c, 32'(wrn_b), 32'(ex_wrn[c]));
            if (go_a) n_go++;
            if (iv_a) begin
                n_iv++;
                last_iv = c;
            end
            mem_valid = tl_mv[c];
            dsec_ov   = tl_ov[c];
            dsec_rdy  = tl_rdy[c];
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                dsec_ov   = 1'b0;
                dsec_rdy  = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reapply_reset(input string tag);
        mem_valid = 1'b0;
        dsec_ov   = 1'b0;
        dsec_rdy  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset(tag);
        rst = 1'b0;
    endtask

    initial begin
        cfg_t tbl[4];
        cfg_t rc;
        int   ng, ni, li;

        //          mem  dsec rdy  spur rnd go iv last_iv
        tbl[0] = '{3,   5,   0,   1'b0, 1'b0, 8, 4, 56};
        tbl[1] = '{1,   1,   10,  1'b0, 1'b0, 8, 4, 68};
        tbl[2] = '{2,   3,   0,   1'b1, 1'b0, 8, 4, 42};
        tbl[3] = '{1,   1,   0,   1'b1, 1'b0, 8, 4, 28};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run(tbl[i], -1, ng, ni, li);
            chk($sformatf("tbl%0d_go_count", i), -1, 32'(ng), 32'(tbl[i].exp_go));
            chk($sformatf("tbl%0d_iv_count", i), -1, 32'(ni), 32'(tbl[i].exp_iv));
            chk($sformatf("tbl%0d_last_iv", i), -1, 32'(li), 32'(tbl[i].exp_last_iv));
            reapply_reset($sformatf("tbl%0d_rst", i));
        end

        // Reset while waiting on the first read: cycle 18 is the first read
        // request for the 3/5/0 timing, so cycle 19 is inside R_WAIT.
        run(tbl[0], 19, ng, ni, li);
        chk_reset("midreset");
        chk("midreset_iv_count", -1, 32'(ni), 0);
        rst = 1'b0;
        run(tbl[0], -1, ng, ni, li);
        chk("restart_go_count", -1, 32'(ng), 8);
        chk("restart_last_iv", -1, 32'(li), 56);
        reapply_reset("restart_rst");

        for (int k = 0; k < 4; k++) begin
            rc = '{0, 0, 0, 1'b1, 1'b1, 8, 4, 0};
            run(rc, -1, ng, ni, li);
            chk($sformatf("rnd%0d_go_count", k), -1, 32'(ng), 32'(rc.exp_go));
            chk($sformatf("rnd%0d_iv_count", k), -1, 32'(ni), 32'(rc.exp_iv));
            reapply_reset($sformatf("rnd%0d_rst", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
